// File: rtl/io_port_sched.sv
// Two-requester round-robin scheduler for the bidirectional I/O port.
// Reprograms direction only on change, inserts a turnaround gap, then performs the write or read.
module io_port_sched #(
  parameter int DATA_WIDTH  = 8,
  parameter int TURN_CYCLES = 1
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic [1:0]            REQ,
  input  logic [1:0]            WR,
  input  logic [DATA_WIDTH-1:0] WDATA0,
  input  logic [DATA_WIDTH-1:0] WDATA1,
  output logic [1:0]            GNT,
  output logic [1:0]            DONE,
  output logic [DATA_WIDTH-1:0] RDATA,
  output logic                  BUSY,
  output logic                  PDR_EN,
  output logic                  DATA_0,
  output logic [DATA_WIDTH-1:0] DATA,
  output logic                  PORT_EN,
  output logic                  PORT_RD,
  input  logic [DATA_WIDTH-1:0] PORT_READ_DATA
);

  typedef enum logic [2:0] {IDLE, DIR, TURN, XFER, CAPT, FIN} state_t;

  localparam logic [3:0] TURN_INIT = (TURN_CYCLES > 0) ? 4'(TURN_CYCLES - 1) : 4'd0;

  state_t                state, state_nx;
  logic                  id_q, wr_q, cur_dir, rr_last;
  logic [DATA_WIDTH-1:0] data_q;
  logic [3:0]            cnt;

  logic                  win, sel_wr;
  logic [DATA_WIDTH-1:0] sel_data;
  logic [1:0]            gnt_nx, done_nx;
  logic                  busy_nx, pdr_en_nx, data0_nx, port_en_nx, port_rd_nx;
  logic [DATA_WIDTH-1:0] data_nx;

  // On a conflict the requester that did not win last time goes first
  assign win      = (REQ == 2'b11) ? ~rr_last : REQ[1];
  assign sel_wr   = (state == IDLE) ? WR[win] : wr_q;
  assign sel_data = (state == IDLE) ? (win ? WDATA1 : WDATA0) : data_q;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state   <= IDLE;
      id_q    <= 1'b0;
      wr_q    <= 1'b0;
      data_q  <= '0;
      cur_dir <= 1'b0;
      rr_last <= 1'b1;
      cnt     <= '0;
      GNT     <= '0;
      DONE    <= '0;
      RDATA   <= '0;
      BUSY    <= 1'b0;
      PDR_EN  <= 1'b0;
      DATA_0  <= 1'b0;
      DATA    <= '0;
      PORT_EN <= 1'b0;
      PORT_RD <= 1'b0;
    end else begin
      state <= state_nx;
      if (state == IDLE && REQ != 2'b00) begin
        id_q    <= win;
        wr_q    <= WR[win];
        data_q  <= win ? WDATA1 : WDATA0;
        rr_last <= win;
      end
      if (state == DIR) cur_dir <= wr_q;
      if (state_nx == TURN && state != TURN) cnt <= TURN_INIT;
      else if (state == TURN)                cnt <= cnt - 4'd1;
      if (state == CAPT) RDATA <= PORT_READ_DATA;
      GNT     <= gnt_nx;
      DONE    <= done_nx;
      BUSY    <= busy_nx;
      PDR_EN  <= pdr_en_nx;
      DATA_0  <= data0_nx;
      DATA    <= data_nx;
      PORT_EN <= port_en_nx;
      PORT_RD <= port_rd_nx;
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (REQ != 2'b00) state_nx = (WR[win] != cur_dir) ? DIR : XFER;
      DIR:  state_nx = (TURN_CYCLES > 0) ? TURN : XFER;
      TURN: if (cnt == 4'd0) state_nx = XFER;
      XFER: state_nx = wr_q ? FIN : CAPT;
      CAPT: state_nx = FIN;
      FIN:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Outputs are computed for the state being entered so they register alongside it
  always_comb begin
    gnt_nx     = '0;
    done_nx    = '0;
    busy_nx    = (state_nx != IDLE);
    pdr_en_nx  = (state_nx == DIR);
    data0_nx   = (state_nx == DIR) && sel_wr;
    port_en_nx = (state_nx == XFER) && sel_wr;
    port_rd_nx = ((state_nx == XFER) && !sel_wr) || (state_nx == CAPT);
    data_nx    = port_en_nx ? sel_data : '0;
    if (state == IDLE && REQ != 2'b00) gnt_nx = {win, ~win};
    if (state_nx == FIN)               done_nx = {id_q, ~id_q};
  end

endmodule

// File: tb/tb_io_port_sched.sv
// Randomized scoreboard bench for io_port_sched: a transaction-timeline model predicts
// grant/direction/transfer/done events, a negedge monitor pops and compares them.
module tb_io_port_sched;
  localparam int DW   = 8;
  localparam int TURN = 1;

  logic          CLK = 1'b0, RST = 1'b0;
  logic [1:0]    REQ = '0, WR = '0;
  logic [DW-1:0] WDATA0 = '0, WDATA1 = '0, PORT_READ_DATA = '0;
  logic [1:0]    GNT, DONE;
  logic [DW-1:0] RDATA, DATA;
  logic          BUSY, PDR_EN, DATA_0, PORT_EN, PORT_RD;

  io_port_sched #(.DATA_WIDTH(DW), .TURN_CYCLES(TURN)) dut (
    .CLK(CLK), .RST(RST), .REQ(REQ), .WR(WR), .WDATA0(WDATA0), .WDATA1(WDATA1),
    .GNT(GNT), .DONE(DONE), .RDATA(RDATA), .BUSY(BUSY), .PDR_EN(PDR_EN), .DATA_0(DATA_0),
    .DATA(DATA), .PORT_EN(PORT_EN), .PORT_RD(PORT_RD), .PORT_READ_DATA(PORT_READ_DATA)
  );

  always #5 CLK = ~CLK;

  typedef struct {int cyc; int id; logic [DW-1:0] val; bit rd;} ev_t;
  ev_t gq[$], pq[$], eq[$], rq[$], dq[$];

  int   cyc = 0, checks = 0, failures = 0;
  logic m_cur_dir = 1'b0, m_rr_last = 1'b1;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d required=%0d (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic ev_t mk(input int c, input int id, input logic [DW-1:0] v, input bit rd);
    ev_t e;
    e.cyc = c; e.id = id; e.val = v; e.rd = rd;
    return e;
  endfunction

  always @(negedge CLK) begin : mon
    ev_t e;
    if (RST) begin
      chk("en_rd_excl", int'(PORT_EN & PORT_RD), 0);
      chk("pdr_excl", int'(PDR_EN & (PORT_EN | PORT_RD)), 0);
      chk("gnt_onehot0", int'($onehot0(GNT)), 1);
      chk("done_onehot0", int'($onehot0(DONE)), 1);
      if (!PORT_EN) chk("data_idle", int'(DATA), 0);
      if (GNT != 2'b00) begin
        if (gq.size() == 0) chk("gnt_unexpected", int'(GNT), 0);
        else begin
          e = gq.pop_front();
          chk("gnt_id", int'(GNT), 1 << e.id);
          chk("gnt_cyc", cyc, e.cyc);
          chk("gnt_busy", int'(BUSY), 1);
        end
      end
      if (PDR_EN) begin
        if (pq.size() == 0) chk("pdr_unexpected", int'(PDR_EN), 0);
        else begin
          e = pq.pop_front();
          chk("pdr_dir", int'(DATA_0), int'(e.val[0]));
          chk("pdr_cyc", cyc, e.cyc);
        end
      end
      if (PORT_EN) begin
        if (eq.size() == 0) chk("wr_unexpected", int'(PORT_EN), 0);
        else begin
          e = eq.pop_front();
          chk("wr_data", int'(DATA), int'(e.val));
          chk("wr_cyc", cyc, e.cyc);
        end
      end
      if (PORT_RD) begin
        if (rq.size() == 0) chk("rd_unexpected", int'(PORT_RD), 0);
        else begin
          e = rq.pop_front();
          chk("rd_cyc", cyc, e.cyc);
        end
      end
      if (DONE != 2'b00) begin
        if (dq.size() == 0) chk("done_unexpected", int'(DONE), 0);
        else begin
          e = dq.pop_front();
          chk("done_id", int'(DONE), 1 << e.id);
          chk("done_cyc", cyc, e.cyc);
          if (e.rd) chk("rdata", int'(RDATA), int'(e.val));
        end
      end
    end
  end

  // One arbitration round: pattern pat is raised; each served requester drops its REQ
  // after its grant unless hold is set (then 4 grants are taken with REQ held).
  task automatic run_round(input logic [1:0] pat, input logic [1:0] wr,
                           input logic [DW-1:0] wd0, input logic [DW-1:0] wd1,
                           input logic [DW-1:0] rd0, input logic [DW-1:0] rd1, input bit hold);
    logic [1:0] pm;
    logic       id;
    int         n, base, pre, xf, dn;
    pm = pat;
    n  = hold ? 4 : $countones(pat);
    @(negedge CLK);
    REQ = pat; WR = wr; WDATA0 = wd0; WDATA1 = wd1;
    for (int k = 0; k < n; k++) begin
      id = (pm == 2'b11) ? ~m_rr_last : pm[1];
      PORT_READ_DATA = id ? rd1 : rd0;
      base = cyc;
      pre  = (wr[id] != m_cur_dir) ? 1 + TURN : 0;
      gq.push_back(mk(base + 1, int'(id), '0, 1'b0));
      if (pre != 0) pq.push_back(mk(base + 1, int'(id), DW'(wr[id]), 1'b0));
      xf = base + 1 + pre;
      if (wr[id]) eq.push_back(mk(xf, int'(id), id ? wd1 : wd0, 1'b0));
      else begin
        rq.push_back(mk(xf, int'(id), '0, 1'b0));
        rq.push_back(mk(xf + 1, int'(id), '0, 1'b0));
      end
      dn = xf + (wr[id] ? 1 : 2);
      dq.push_back(mk(dn, int'(id), id ? rd1 : rd0, !wr[id]));
      m_cur_dir = wr[id];
      m_rr_last = id;
      @(negedge CLK);
      if (!hold) begin
        pm[id] = 1'b0;
        REQ = pm;
      end
      while (cyc < dn + 1) @(negedge CLK);
    end
    REQ = 2'b00;
  endtask

  initial begin : wdog
    #2000000;
    $display("FAIL watchdog expired (cycle %0d)", cyc);
    $fatal(1, "timeout");
  end

  initial begin : drv
    logic w;
    repeat (3) @(negedge CLK);
    chk("reset_outputs", int'({GNT, DONE, RDATA, BUSY, PDR_EN, DATA_0, DATA, PORT_EN, PORT_RD}), 0);
    RST = 1'b1;
    repeat (2) @(negedge CLK);

    run_round(2'b01, 2'b01, 8'hA5, 8'h00, 8'h00, 8'h00, 1'b0); // direction change to output
    run_round(2'b01, 2'b01, 8'h3C, 8'h00, 8'h00, 8'h00, 1'b0); // no change
    run_round(2'b10, 2'b00, 8'h00, 8'h00, 8'h00, 8'h5A, 1'b0); // back to input
    run_round(2'b11, 2'b00, 8'h00, 8'h00, 8'h11, 8'h22, 1'b1); // held conflict alternates

    // Reset during the turnaround gap aborts the write
    @(negedge CLK);
    w = ~m_cur_dir;
    REQ = 2'b01; WR = {1'b0, w}; WDATA0 = 8'hEE;
    gq.push_back(mk(cyc + 1, 0, '0, 1'b0));
    pq.push_back(mk(cyc + 1, 0, DW'(w), 1'b0));
    @(negedge CLK);
    REQ = 2'b00;
    @(posedge CLK);
    #2 RST = 1'b0;
    #1 chk("async_reset_outputs", int'({GNT, DONE, BUSY, PDR_EN, DATA_0, DATA, PORT_EN, PORT_RD}), 0);
    gq.delete(); pq.delete(); eq.delete(); rq.delete(); dq.delete();
    m_cur_dir = 1'b0;
    m_rr_last = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    run_round(2'b01, 2'b01, 8'h77, 8'h00, 8'h00, 8'h00, 1'b0); // reprograms direction
    run_round(2'b11, 2'b11, 8'h12, 8'h34, 8'h00, 8'h00, 1'b0); // requester 0 wins after reset

    for (int r = 0; r < 300; r++) begin
      run_round(2'($urandom_range(1, 3)), 2'($urandom), 8'($urandom), 8'($urandom),
                8'($urandom), 8'($urandom), $urandom_range(0, 7) == 0);
      repeat ($urandom_range(0, 2)) @(negedge CLK);
    end

    repeat (4) @(negedge CLK);
    chk("gq_empty", gq.size(), 0);
    chk("pq_empty", pq.size(), 0);
    chk("eq_empty", eq.size(), 0);
    chk("rq_empty", rq.size(), 0);
    chk("dq_empty", dq.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
